// File: rtl/msub_pkg.sv
// Shared definitions for the multibyte subtractor: FSM state encoding,
// byte width and the counter-width helper.
package msub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int MSUB_BYTE_W = 8;

  // Number of bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int w;
    w = 0;
    while ((32'sd1 <<< w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/multibyte_subtractor_subtractor.sv
// 8-bit subtract stage: diff = a - b - bin, with borrow-out and signed
// overflow of the byte. Purely combinational, reused once per RUN cycle.
module subtractor
  import msub_pkg::*;
(
  input  logic [MSUB_BYTE_W-1:0] a_i,
  input  logic [MSUB_BYTE_W-1:0] b_i,
  input  logic                   bin_i,
  output logic [MSUB_BYTE_W-1:0] diff_o,
  output logic                   bout_o,
  output logic                   overflow_o
);

  logic [MSUB_BYTE_W:0] full_s;

  // One extra bit turns the wrap of a negative result into the borrow-out.
  always_comb begin
    full_s     = {1'b0, a_i} - {1'b0, b_i} - {{MSUB_BYTE_W{1'b0}}, bin_i};
    diff_o     = full_s[MSUB_BYTE_W-1:0];
    bout_o     = full_s[MSUB_BYTE_W];
    overflow_o = (a_i[MSUB_BYTE_W-1] ^ b_i[MSUB_BYTE_W-1]) &
                 (full_s[MSUB_BYTE_W-1] ^ a_i[MSUB_BYTE_W-1]);
  end

endmodule

// File: rtl/multibyte_subtractor.sv
// Sequential wide subtractor: A - B - bin computed one byte per clock,
// LSB first, through a single shared 8-bit subtractor stage.
// Optional feature: define MSUB_ZERO_FLAG_EN to add the `zero` result flag.
module multibyte_subtractor
  import msub_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [MSUB_BYTE_W*NBYTES-1:0]   a,
  input  logic [MSUB_BYTE_W*NBYTES-1:0]   b,
  input  logic                            bin,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MSUB_BYTE_W*NBYTES-1:0]   diff,
`ifdef MSUB_ZERO_FLAG_EN
  output logic                            zero,
`endif
  output logic                            bout,
  output logic                            overflow
);

  localparam int W     = MSUB_BYTE_W * NBYTES;
  localparam int CNT_W = clog2(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   borrow_q, borrow_d;
  logic [W-1:0]           a_q, a_d;
  logic [W-1:0]           b_q, b_d;
  logic [W-1:0]           diff_q, diff_d;
  logic                   bout_q, bout_d;
  logic                   ovf_q, ovf_d;
`ifdef MSUB_ZERO_FLAG_EN
  logic                   zacc_q, zacc_d;
  logic                   zero_q, zero_d;
`endif

  logic [MSUB_BYTE_W-1:0] sub_a_s, sub_b_s, sub_diff_s;
  logic                   sub_bout_s, sub_ovf_s;
  logic                   last_s;
  int                     base_s;

  // Select the operand bytes addressed by the byte counter.
  always_comb begin
    base_s  = int'(cnt_q) * MSUB_BYTE_W;
    sub_a_s = a_q[base_s +: MSUB_BYTE_W];
    sub_b_s = b_q[base_s +: MSUB_BYTE_W];
    last_s  = (cnt_q == LAST);
  end

  subtractor u_sub (
    .a_i        (sub_a_s),
    .b_i        (sub_b_s),
    .bin_i      (borrow_q),
    .diff_o     (sub_diff_s),
    .bout_o     (sub_bout_s),
    .overflow_o (sub_ovf_s)
  );

  // State register and datapath registers; rst aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      borrow_q <= 1'b0;
      a_q      <= {W{1'b0}};
      b_q      <= {W{1'b0}};
      diff_q   <= {W{1'b0}};
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef MSUB_ZERO_FLAG_EN
      zacc_q   <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
`ifdef MSUB_ZERO_FLAG_EN
      zacc_q   <= zacc_d;
      zero_q   <= zero_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, walk the bytes in RUN, hold in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = RUN;
        else          state_d = IDLE;
      end
      RUN: begin
        if (last_s) state_d = DONE;
        else        state_d = RUN;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
        else           state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: latch operands, then store one diff byte per cycle.
  always_comb begin
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
`ifdef MSUB_ZERO_FLAG_EN
    zacc_d   = zacc_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = {CNT_W{1'b0}};
`ifdef MSUB_ZERO_FLAG_EN
          zacc_d   = 1'b0;
`endif
        end else begin
          cnt_d    = cnt_q;
        end
      end
      RUN: begin
        diff_d[base_s +: MSUB_BYTE_W] = sub_diff_s;
        borrow_d = sub_bout_s;
`ifdef MSUB_ZERO_FLAG_EN
        zacc_d   = zacc_q | (|sub_diff_s);
`endif
        if (last_s) begin
          // Top byte: its borrow and signed overflow are the full-width flags.
          cnt_d  = {CNT_W{1'b0}};
          bout_d = sub_bout_s;
          ovf_d  = sub_ovf_s;
`ifdef MSUB_ZERO_FLAG_EN
          zero_d = ~(zacc_q | (|sub_diff_s));
`endif
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        cnt_d = cnt_q;
      end
      default: begin
        cnt_d = {CNT_W{1'b0}};
      end
    endcase
  end

  // Output decode: handshake flags from state, results straight from registers.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    diff      = diff_q;
    bout      = bout_q;
    overflow  = ovf_q;
`ifdef MSUB_ZERO_FLAG_EN
    zero      = zero_q;
`endif
  end

endmodule

// File: tb/tb_multibyte_subtractor.sv
// Self-checking bench for multibyte_subtractor (NBYTES=4): directed cases,
// backpressure, reset aborts and randomized operations against a plain
// integer-arithmetic reference model.
module tb_multibyte_subtractor;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;
`ifdef MSUB_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multibyte_subtractor #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
`ifdef MSUB_ZERO_FLAG_EN
    .zero      (zero),
`endif
    .bout      (bout),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: full-width unsigned and signed arithmetic in 64-bit integers.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                                output logic [W-1:0] d, output logic bo, output logic ov);
    longint ur, sr;
    ur = longint'({32'd0, av}) - longint'({32'd0, bv}) - longint'({63'd0, bi});
    sr = longint'($signed(av)) - longint'($signed(bv)) - longint'({63'd0, bi});
    d  = ur[W-1:0];
    bo = (ur < 64'sd0);
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
  endfunction

  task automatic check_outputs(input string tag, input logic [W-1:0] ed, input logic eb, input logic eo);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"}, overflow, eo);
`ifdef MSUB_ZERO_FLAG_EN
    check({tag, "_zero"}, zero, (ed == {W{1'b0}}));
`endif
  endtask

  // Start at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        input int hold, input logic early);
    logic [W-1:0] ed;
    logic         eb, eo;
    model(av, bv, bi, ed, eb, eo);
    check("idle_in_ready", in_ready, 1'b1);
    a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = early;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= NB + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k <= NB) check("run_out_valid", out_valid, 1'b0);
    end
    check("done_out_valid", out_valid, 1'b1);
    check("done_in_ready", in_ready, 1'b0);
    check_outputs("result", ed, eb, eo);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        in_valid = 1'b1; a = ~av; b = $urandom; bin = ~bi;
        @(negedge clk);
        check("hold_out_valid", out_valid, 1'b1);
        check("hold_in_ready", in_ready, 1'b0);
        check_outputs("hold", ed, eb, eo);
      end
      in_valid = 1'b0; a = av; b = bv; bin = bi;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("taken_out_valid", out_valid, 1'b0);
    check("taken_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] av, bv;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = {W{1'b0}}; b = {W{1'b0}}; bin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check_outputs("rst", {W{1'b0}}, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(32'h0001_0000, 32'h0000_0001, 1'b0, 0, 1'b1);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 0, 1'b0);
    // Backpressure: five cycles held in DONE with in_valid pulses
    run_op(32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 5, 1'b0);

    // Reset during the second RUN cycle
    a = 32'hFFFF_FFFF; b = 32'h0101_0101; bin = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check_outputs("abort", {W{1'b0}}, 1'b0, 1'b0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, 1'b0);

    // Reset while DONE with out_ready low
    a = 32'h0000_0005; b = 32'h0000_0009; bin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (NB) @(negedge clk);
    check("done_before_rst", out_valid, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_done_out_valid", out_valid, 1'b0);
    check("rst_done_in_ready", in_ready, 1'b1);

    // rst together with in_valid: nothing latched
    rst = 1'b1; in_valid = 1'b1; a = 32'hCAFE_F00D; b = 32'h1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check("rst_win_in_ready", in_ready, 1'b1);
    for (int i = 0; i < NB + 2; i++) begin
      @(negedge clk);
      check("rst_win_idle", out_valid, 1'b0);
    end

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      av = $urandom;
      if ($urandom_range(0, 3) == 0) bv = av - W'($urandom_range(0, 2));
      else                           bv = $urandom;
      run_op(av, bv, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multibyte_subtractor.md
# multibyte_subtractor

Sequential wide subtractor: accepts two NBYTES-byte operands over a valid/ready handshake and computes A − B − bin one byte per clock, LSB first. Each byte goes through the existing 8-bit `subtractor` stage, and the borrow chains between bytes. Sits directly upstream of that stage: it sequences operand bytes into it and collects its diff, borrow and overflow into a full-width result.

## Interface
- `NBYTES`, default 4: operand width in bytes; legal values are 2..16.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: operand pair present.
- `in_ready` out 1: block can accept operands.
- `a` in 8*NBYTES: minuend.
- `b` in 8*NBYTES: subtrahend.
- `bin` in 1: borrow-in; applies to byte 0 only.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes the result.
- `diff` out 8*NBYTES: A − B − bin, modulo 2^(8*NBYTES).
- `bout` out 1: final borrow; high when A < B + bin, unsigned.
- `overflow` out 1: signed overflow of the full-width subtraction.
- `zero` out 1: high when `diff` is all zeros. Present only with MSUB_ZERO_FLAG_EN.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&`in_ready`: latch `a`, `b`, `bin`; set borrow register to `bin`; clear byte counter; go to RUN.
- **RUN**
  - Byte k = counter. Feed `a[8k+:8]`, `b[8k+:8]` and the borrow register to the `subtractor` instance.
  - At the edge: store its diff into `diff[8k+:8]`, load its bout into the borrow register, increment the counter.
  - When k = NBYTES−1: also register `bout` and `overflow` from that top byte, then go to DONE.
- **DONE**
  - `out_valid`=1. Outputs stay stable until `out_valid`&`out_ready`, then go to IDLE.
- `in_ready` is high in IDLE only. The block ignores `in_valid` in RUN and DONE; upstream holds its operands.
- Arithmetic:
  - Borrow chains byte to byte, so `bout` equals the unsigned compare A < B + bin.
  - `overflow` is the signed overflow of the top byte: (a_msb ^ b_msb) & (diff_msb ^ a_msb).
  - No carry-out beyond 8*NBYTES bits.
- `diff` bytes not yet written during RUN hold their previous values. Consumers sample only on `out_valid`.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `diff`=0, `bout`=0, `overflow`=0, `zero`=0, counter 0, borrow register 0.
- Latency: for a handshake in cycle T, `out_valid` is first high in cycle T+NBYTES+1.
- Throughput: one operation per NBYTES+2 cycles when `out_ready` is held high. There is no overlap between the result being taken and a new acceptance.
- `rst` in any state, including mid-RUN or in DONE with `out_ready` low:
  - The operation is aborted and the result discarded.
  - `out_valid`=0 and `in_ready`=1 in the following cycle.
- `rst` asserted together with `in_valid`: `rst` wins and nothing is latched.
- `out_ready` held high while `out_valid` is low has no effect.

## Configuration
- `MSUB_ZERO_FLAG_EN` defined:
  - Adds a `zero` output register, updated at the same edge as `bout`/`overflow`.
  - Its value is the OR-reduction of each byte's diff, accumulated during RUN and inverted on entry to DONE.
- Undefined: no `zero` port and no accumulator logic.

## Structure
- Package `msub_pkg` holds:
  - the state enum (IDLE/RUN/DONE);
  - `MSUB_BYTE_W` = 8;
  - the counter width function clog2(NBYTES).
- One sub-module: the existing 8-bit `subtractor`, instantiated once and reused every RUN cycle.

## Test plan
- NBYTES=4, a=0x00010000, b=0x00000001, bin=0 -> diff=0x0000FFFF, bout=0, overflow=0; `out_valid` high exactly 5 cycles after the handshake.
- a=0x00000000, b=0x00000001, bin=0 -> diff=0xFFFFFFFF, bout=1, overflow=0.
- a=0x80000000, b=0x00000001, bin=0 -> diff=0x7FFFFFFF, bout=0, overflow=1.
- a=0x12345678, b=0x12345677, bin=1 -> diff=0x00000000, bout=0, overflow=0, zero=1 when MSUB_ZERO_FLAG_EN is defined.
- Backpressure:
  - Stimulus: hold `out_ready`=0 for 5 cycles in DONE.
  - Required: outputs stable, `in_ready`=0, and an `in_valid` pulse is ignored. Then `out_ready`=1 -> IDLE next cycle.
- Reset: assert `rst` in the 2nd RUN cycle -> next cycle `out_valid`=0, `in_ready`=1, all outputs 0. A new operation then completes correctly.
